exc_ctrl: RTL

- Exception/interrupt sequencer for the multi-cycle MIPS core.
- Collects synchronous exception requests from execute and hardware interrupt lines, and prioritises them.
- Builds the 32-bit cause word that drives the `cause` register's `reason` input, captures the EPC, and runs the flush → redirect → handler → eret sequence toward fetch.

---
 rtl/exc_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: prioritises requests, builds the cause word, saves EPC,
// and sequences flush -> redirect -> handler -> eret. Define EXC_INT_SYNC_EN to add a 2-flop int_req synchroniser.
module exc_ctrl #(
    parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic [5:0]  int_req,
    input  logic [5:0]  int_mask,
    input  logic        int_en,
    input  logic        eret,
    output logic [31:0] reason,
    output logic        reason_we,
    output logic [31:0] epc,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        in_handler
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIR,
        S_HANDLER,
        S_RETURN
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [4:0]  cause_code, cause_code_n;
    logic        cause_bd, cause_bd_n;
    logic [31:0] epc_n, redirect_pc_n;
    logic        reason_we_n;
    logic [5:0]  ip;
    logic        take_int;

`ifdef EXC_INT_SYNC_EN
    logic [5:0] int_meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_meta <= '0;
            ip       <= '0;
        end else begin
            int_meta <= int_req;
            ip       <= int_meta;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ip <= '0;
        else       ip <= int_req;
    end
`endif

    assign take_int = int_en & |(ip & int_mask);

    // Pending lines are shown live; the other fields hold the last recorded exception.
    assign reason = {cause_bd, 15'b0, ip, 3'b0, cause_code, 2'b0};

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_n       = state;
        cnt_n         = cnt;
        cause_code_n  = cause_code;
        cause_bd_n    = cause_bd;
        epc_n         = epc;
        redirect_pc_n = redirect_pc;
        reason_we_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (exc_valid || take_int) begin
                    cause_code_n = exc_valid ? exc_code : 5'd0;
                    cause_bd_n   = bd;
                    epc_n        = bd ? pc - 32'd4 : pc;
                    reason_we_n  = 1'b1;
                    cnt_n        = FLUSH_LOAD;
                    state_n      = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (cnt == 4'd0) begin
                    redirect_pc_n = HANDLER_PC;
                    state_n       = S_REDIR;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_REDIR: state_n = S_HANDLER;
            S_HANDLER: begin
                // A nested exception keeps the original return address.
                if (exc_valid) begin
                    cause_code_n = exc_code;
                    cause_bd_n   = bd;
                    reason_we_n  = 1'b1;
                    cnt_n        = FLUSH_LOAD;
                    state_n      = S_FLUSH;
                end else if (eret) begin
                    redirect_pc_n = epc;
                    state_n       = S_RETURN;
                end
            end
            S_RETURN: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cause_code  <= '0;
            cause_bd    <= 1'b0;
            epc         <= '0;
            redirect_pc <= '0;
            reason_we   <= 1'b0;
            flush       <= 1'b0;
            redirect    <= 1'b0;
            in_handler  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cause_code  <= cause_code_n;
            cause_bd    <= cause_bd_n;
            epc         <= epc_n;
            redirect_pc <= redirect_pc_n;
            reason_we   <= reason_we_n;
            flush       <= (state_n == S_FLUSH);
            redirect    <= (state_n == S_REDIR) || (state_n == S_RETURN);
            in_handler  <= (state_n == S_HANDLER);
        end
    end

endmodule
